// File: rtl/sprite_line_evaluator_pkg.sv
// Shared definitions for the sprite line evaluator: SAT bit layout, the packed
// attribute word handed to the renderer, and FSM encodings.
package sprite_line_evaluator_pkg;

    // SAT word0 fields
    localparam int SAT_X_LSB     = 23;
    localparam int SAT_Y_LSB     = 15;
    // SAT word1 fields
    localparam int SAT_TILE_LSB  = 24;
    localparam int SAT_PAL_LSB   = 19;
    localparam int SAT_HFLIP_BIT = 18;
    localparam int SAT_VFLIP_BIT = 17;
    localparam int SAT_PRIO_BIT  = 16;
    localparam int SAT_DIS_BIT   = 15;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] tile;
        logic [4:0] pal;
        logic       hflip;
        logic       vflip;
        logic       prio;
        logic       dis;
    } sprite_attr_t;

    typedef struct packed {
        sprite_attr_t attr;
        logic [2:0]   vpix;
    } slot_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } eval_state_t;

    function automatic logic [2:0] tile_row(input logic [2:0] dy, input logic vflip);
        return vflip ? (3'd7 - dy) : dy;
    endfunction

endpackage

// File: rtl/sprite_line_evaluator_if.sv
// Control, VRAM32 read port and renderer read port of the sprite line evaluator.
// master = line sequencer / VRAM / renderer side, slave = evaluator.
interface sprite_line_evaluator_if #(
    parameter int MAX_SLOTS = 8
);
    localparam int SEL_W = $clog2(MAX_SLOTS);

    logic                                  start;
    logic [7:0]                            line;
    logic                                  swap;
    logic [13:0]                           vram32_addr;
    logic [31:0]                           vram32_q;
    logic                                  busy;
    logic                                  done;
    logic                                  overflow;
    logic                                  late;
    logic [SEL_W-1:0]                      slot_sel;
    logic [MAX_SLOTS-1:0]                  slot_valid;
    sprite_line_evaluator_pkg::sprite_attr_t slot_attr;
    logic [2:0]                            slot_vpix;

    modport master (
        output start, line, swap, vram32_q, slot_sel,
        input  vram32_addr, busy, done, overflow, late, slot_valid, slot_attr, slot_vpix
    );

    modport slave (
        input  start, line, swap, vram32_q, slot_sel,
        output vram32_addr, busy, done, overflow, late, slot_valid, slot_attr, slot_vpix
    );

endinterface

// File: rtl/sprite_line_evaluator_slot_buffer.sv
// Double-banked slot store: evaluator writes the back bank, renderer reads the
// front bank through a combinational mux. Swap flips bank roles.
module sprite_line_evaluator_slot_buffer
    import sprite_line_evaluator_pkg::*;
#(
    parameter int MAX_SLOTS = 8,
    parameter int SEL_W     = $clog2(MAX_SLOTS)
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_slot,
    input  slot_entry_t          wr_data,
    input  logic                 clr_back,
    input  logic                 swap,
    input  logic                 abort,
    input  logic [SEL_W-1:0]     slot_sel,
    output logic [MAX_SLOTS-1:0] slot_valid,
    output sprite_attr_t         slot_attr,
    output logic [2:0]           slot_vpix
);

    logic                      front_q;
    logic [1:0][MAX_SLOTS-1:0] mask_q;
    slot_entry_t               bank_q [2][MAX_SLOTS];
    slot_entry_t               rd_entry;
    logic                      rd_valid;

    // Swap makes the old back bank visible and recycles the old front as the
    // new (empty) back bank, so no data is copied.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            if (wr_en)
                mask_q[!front_q][wr_slot] <= 1'b1;
            if (abort) begin
                mask_q <= '0;
            end else if (swap) begin
                front_q         <= !front_q;
                mask_q[front_q] <= '0;
            end else if (clr_back) begin
                mask_q[!front_q] <= '0;
            end
        end
    end

    // Payload needs no reset: it is only ever seen through the valid mask.
    always_ff @(posedge vga_clk) begin
        if (wr_en)
            bank_q[!front_q][wr_slot] <= wr_data;
    end

    assign rd_entry   = bank_q[front_q][slot_sel];
    assign rd_valid   = mask_q[front_q][slot_sel];
    assign slot_valid = mask_q[front_q];
    assign slot_attr  = rd_valid ? rd_entry.attr : '0;
    assign slot_vpix  = rd_valid ? rd_entry.vpix : '0;

endmodule

// File: rtl/sprite_line_evaluator.sv
// Scans the SAT during line N and collects up to MAX_SLOTS sprites covering
// line N+1 into the back bank of the slot buffer.
module sprite_line_evaluator
    import sprite_line_evaluator_pkg::*;
#(
    parameter int          NUM_SPRITES = 64,
    parameter int          MAX_SLOTS   = 8,
    parameter logic [13:0] SAT_BASE    = 14'h0600
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    sprite_line_evaluator_if.slave   bus
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SEL_W = $clog2(MAX_SLOTS);
    localparam int CNT_W = SEL_W + 1;

    eval_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       line_q;
    logic [8:0]       x_q;
    logic [7:0]       y_q;
    logic             overflow_q;
    logic             late_q;

    logic             busy;
    logic             abort;
    logic             cap_w0;
    logic             clr_back;
    logic             wr_en;
    logic             ovf_set;
    logic [13:0]      addr;
    logic [13:0]      w0_addr;

    logic [31:0]      q;
    logic [8:0]       dy;
    logic             hit;
    sprite_attr_t     cur_attr;
    slot_entry_t      wr_data;
    logic             unused_q;

    assign q        = bus.vram32_q;
    assign unused_q = ^q[SAT_DIS_BIT-1:0];

    // word0 is registered in RD1; word1 is used straight off the RAM in CHK
    assign cur_attr = '{
        x:     x_q,
        y:     y_q,
        tile:  q[SAT_TILE_LSB +: 8],
        pal:   q[SAT_PAL_LSB +: 5],
        hflip: q[SAT_HFLIP_BIT],
        vflip: q[SAT_VFLIP_BIT],
        prio:  q[SAT_PRIO_BIT],
        dis:   q[SAT_DIS_BIT]
    };

    // 9-bit difference so sprites near the bottom never wrap onto line 0
    assign dy      = {1'b0, line_q} - {1'b0, y_q};
    assign hit     = (dy[8:3] == '0) && !cur_attr.dis;
    assign wr_data = '{attr: cur_attr, vpix: tile_row(dy[2:0], cur_attr.vflip)};

    assign w0_addr = SAT_BASE + 14'({idx_q, 1'b0});
    assign busy    = (state_q == ST_RD0) || (state_q == ST_RD1) || (state_q == ST_CHK);
    assign abort   = bus.swap && busy;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        addr     = '0;
        cap_w0   = 1'b0;
        clr_back = 1'b0;
        wr_en    = 1'b0;
        ovf_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RD0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    clr_back = 1'b1;
                end
            end
            ST_RD0: begin
                addr    = w0_addr;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                addr    = w0_addr + 14'd1;
                cap_w0  = 1'b1;
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (hit) begin
                    if (cnt_q == CNT_W'(MAX_SLOTS)) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (ovf_set || (idx_q == IDX_W'(NUM_SPRITES - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    // next sprite's word0 read overlaps this decision
                    addr    = w0_addr + 14'd2;
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            wr_en   = 1'b0;
            ovf_set = 1'b0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            late_q  <= abort;
            if (clr_back)
                line_q <= bus.line;
            if (cap_w0) begin
                x_q <= q[SAT_X_LSB +: 9];
                y_q <= q[SAT_Y_LSB +: 8];
            end
            if (clr_back)
                overflow_q <= 1'b0;
            else if (ovf_set)
                overflow_q <= 1'b1;
        end
    end

    assign bus.vram32_addr = addr;
    assign bus.busy        = busy;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.overflow    = overflow_q;
    assign bus.late        = late_q;

    sprite_line_evaluator_slot_buffer #(
        .MAX_SLOTS (MAX_SLOTS),
        .SEL_W     (SEL_W)
    ) u_slots (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_slot    (cnt_q[SEL_W-1:0]),
        .wr_data    (wr_data),
        .clr_back   (clr_back),
        .swap       (bus.swap),
        .abort      (abort),
        .slot_sel   (bus.slot_sel),
        .slot_valid (bus.slot_valid),
        .slot_attr  (bus.slot_attr),
        .slot_vpix  (bus.slot_vpix)
    );

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench: a behavioural SAT scan predicts each line's slots when the
// scan is launched; predictions are popped at done and after each swap.
module tb_sprite_line_evaluator;
    import sprite_line_evaluator_pkg::*;

    localparam int          NS   = 64;
    localparam logic [13:0] BASE = 14'h0600;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    sprite_line_evaluator_if #(.MAX_SLOTS(8)) bus();

    sprite_line_evaluator #(
        .NUM_SPRITES (NS),
        .MAX_SLOTS   (8),
        .SAT_BASE    (BASE)
    ) dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    logic [31:0] sat [0:2*NS-1];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous VRAM32: data one cycle after the address
    always @(posedge clk) begin
        if (bus.vram32_addr >= BASE && bus.vram32_addr < BASE + 14'(2*NS))
            bus.vram32_q <= sat[int'(bus.vram32_addr - BASE)];
        else
            bus.vram32_q <= 32'hA5A5_A5A5;
    end

    typedef struct {
        int   done_cyc;
        logic ovf;
    } hdr_t;

    hdr_t        hdr_q  [$];
    logic [7:0]  mask_q [$];
    logic [36:0] slot_q [$];
    int n_chk  = 0;
    int n_pass = 0;
    int s_cyc  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic put(input int i, input logic [8:0] x, input logic [7:0] y,
                       input logic [7:0] tile, input logic [4:0] pal,
                       input logic hf, input logic vf, input logic pr, input logic dis);
        sat[2*i]   = {x, y, 15'($urandom)};
        sat[2*i+1] = {tile, pal, hf, vf, pr, dis, 15'($urandom)};
    endtask

    task automatic clear_sat();
        for (int i = 0; i < NS; i++) put(i, 9'd0, 8'd240, 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_model(input logic [7:0] ln);
        int         n    = 0;
        logic       ovf  = 1'b0;
        int         dcyc = 2*NS + 2;
        logic [7:0] m    = '0;
        logic [31:0] w0, w1;
        int         dy;
        for (int i = 0; i < NS; i++) begin
            w0 = sat[2*i];
            w1 = sat[2*i+1];
            dy = int'(ln) - int'(w0[22:15]);
            if (dy >= 0 && dy < 8 && !w1[15]) begin
                if (n == 8) begin
                    ovf  = 1'b1;
                    dcyc = 4 + 2*i;
                    break;
                end
                slot_q.push_back({w0[31:23], w0[22:15], w1[31:15], (w1[17] ? 3'(7 - dy) : 3'(dy))});
                m[n] = 1'b1;
                n++;
            end
        end
        hdr_q.push_back('{dcyc, ovf});
        mask_q.push_back(m);
    endtask

    task automatic launch(input logic [7:0] ln, input logic with_swap);
        @(negedge clk);
        push_model(ln);
        bus.line  = ln;
        bus.start = 1'b1;
        bus.swap  = with_swap;
        s_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.swap  = 1'b0;
        chk("busy_cycle1", bus.busy, 1);
    endtask

    task automatic wait_done();
        hdr_t h = hdr_q.pop_front();
        while (!bus.done && (cyc - s_cyc) < 300) @(negedge clk);
        chk("done_cycle", cyc - s_cyc, h.done_cyc);
        chk("done_pulse", bus.done, 1);
        chk("overflow", bus.overflow, h.ovf);
        chk("busy_at_done", bus.busy, 0);
    endtask

    task automatic check_front();
        logic [7:0]  m = mask_q.pop_front();
        logic [36:0] e;
        chk("slot_valid", bus.slot_valid, m);
        for (int k = 0; k < 8; k++) begin
            bus.slot_sel = 3'(k);
            #1;
            if (m[k]) begin
                e = slot_q.pop_front();
                chk($sformatf("slot%0d_attr", k), bus.slot_attr, e[36:3]);
                chk($sformatf("slot%0d_vpix", k), bus.slot_vpix, e[2:0]);
            end else begin
                chk($sformatf("slot%0d_attr_empty", k), bus.slot_attr, 0);
            end
        end
    endtask

    task automatic swap_check();
        @(negedge clk);
        bus.swap = 1'b1;
        @(negedge clk);
        bus.swap = 1'b0;
        check_front();
        chk("late_idle_swap", bus.late, 0);
    endtask

    initial begin
        int nd;
        bus.start    = 1'b0;
        bus.swap     = 1'b0;
        bus.line     = '0;
        bus.slot_sel = '0;
        clear_sat();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_late", bus.late, 0);
        chk("rst_addr", bus.vram32_addr, 0);
        chk("rst_valid", bus.slot_valid, 0);
        chk("rst_attr", bus.slot_attr, 0);
        chk("rst_vpix", bus.slot_vpix, 0);
        rst_n = 1'b1;

        // T1: single sprite, line 6
        put(0, 9'd4, 8'd4, 8'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'd6, 1'b0);
        wait_done();
        swap_check();
        bus.slot_sel = 3'd0;
        #1;
        chk("t1_vpix", bus.slot_vpix, 3'd2);
        chk("t1_mask", bus.slot_valid, 8'h01);
        chk("t1_attr", bus.slot_attr, {9'd4, 8'd4, 8'd1, 5'd1, 4'b0000});

        // T2: vflip, bottom row, just past the sprite, no-wrap cases
        put(0, 9'd4, 8'd4, 8'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        launch(8'd6, 1'b0);
        wait_done();
        swap_check();
        bus.slot_sel = 3'd0;
        #1;
        chk("t2_vpix_vflip", bus.slot_vpix, 3'd5);
        put(0, 9'd4, 8'd4, 8'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'd11, 1'b0);
        wait_done();
        launch(8'd12, 1'b1);      // start+swap together: line 11 result goes front
        check_front();
        wait_done();
        swap_check();
        put(0, 9'd4, 8'd0, 8'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'd255, 1'b0);
        wait_done();
        swap_check();
        put(0, 9'd4, 8'd250, 8'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'd1, 1'b0);
        wait_done();
        swap_check();

        // T3: ten hits, overflow and early stop
        clear_sat();
        for (int i = 0; i < 10; i++)
            put(i, 9'(10*i + 3), 8'd18, 8'(i + 16), 5'(i), i[0], i[1], i[2], 1'b0);
        launch(8'd20, 1'b0);
        wait_done();
        swap_check();
        chk("t3_mask", bus.slot_valid, 8'hFF);
        chk("t3_ovf_held", bus.overflow, 1);

        // T4: compaction around a disabled sprite
        clear_sat();
        put(2, 9'd100, 8'd30, 8'h22, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        put(5, 9'd200, 8'd30, 8'h55, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        put(9, 9'd300, 8'd28, 8'h99, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        launch(8'd31, 1'b0);
        wait_done();
        swap_check();
        chk("t4_mask", bus.slot_valid, 8'h03);

        // T5: ignored start at cycle 20, swap at cycle 50 aborts
        @(negedge clk);
        bus.line  = 8'd31;
        bus.start = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc - s_cyc < 20) @(negedge clk);
        bus.start = 1'b1;
        bus.line  = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t5_no_restart_addr", bus.vram32_addr, BASE + 14'd20);
        chk("t5_busy", bus.busy, 1);
        while (cyc - s_cyc < 50) @(negedge clk);
        bus.swap = 1'b1;
        @(negedge clk);
        bus.swap = 1'b0;
        chk("t5_late", bus.late, 1);
        chk("t5_busy_after", bus.busy, 0);
        chk("t5_valid", bus.slot_valid, 0);
        @(negedge clk);
        chk("t5_late_pulse", bus.late, 0);
        nd = 0;
        repeat (90) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("t5_no_done", nd, 0);

        // refill the front bank, then T6: async reset mid-scan
        launch(8'd31, 1'b0);
        wait_done();
        swap_check();
        @(negedge clk);
        bus.line  = 8'd31;
        bus.start = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc - s_cyc < 40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_addr", bus.vram32_addr, 0);
        chk("t6_valid", bus.slot_valid, 0);
        chk("t6_attr", bus.slot_attr, 0);
        chk("t6_vpix", bus.slot_vpix, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (150) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("t6_no_done", nd, 0);
        clear_sat();
        put(0, 9'd4, 8'd4, 8'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'd6, 1'b0);
        wait_done();
        swap_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
